score_keeper: RTL



---
 rtl/pong_pkg.sv | 31 +++
 rtl/point_edge_det.sv | 30 +++
 rtl/score_keeper.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: game state encoding, winner codes and score
// digit sizing shared between the score keeper and the score decoder.
package pong_pkg;

    localparam int unsigned SCORE_W   = 4;
    localparam int unsigned MAX_DIGIT = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_HOLD      = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    // Tennis-style serve side: flips every two total points.
    // Bit 1 of the 4-bit sum matches bit 1 of the true sum, so wrap is harmless.
    function automatic logic serve_side(input logic [SCORE_W-1:0] a,
                                        input logic [SCORE_W-1:0] b);
        logic [SCORE_W-1:0] sum;
        sum = SCORE_W'(a + b);
        return sum[1];
    endfunction

endpackage

// File: rtl/point_edge_det.sv
// Registers a level point input and flags its 0->1 transition.
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset
//   d       level input from the ball logic
//   rise_c  combinational one-cycle pulse when the registered level rises
module point_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise_c
);

    logic sync_q;
    logic prev_q;

    // Capture the input, then keep one cycle of history for the edge compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= d;
            prev_q <= sync_q;
        end
    end

    assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: tracks per-player BCD-digit scores from point events and
// sequences serve / rally / post-point pause / game over.
// Build option: define SCORE_SERVE_ALT_EN to alternate the serve side every
// two total points; otherwise the loser of the last point receives the serve.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   start      level; begins a game from IDLE or GAME_OVER
//   p1_point   level; ball passed player 2, player 1 scores
//   p2_point   level; ball passed player 1, player 2 scores
//   serve_ack  ball logic has launched the serve
//   p1s, p2s   player scores, 0..9
//   serve_req  request ball launch
//   serve_dir  0 = toward player 2, 1 = toward player 1
//   freeze     ball/paddle logic holds still while high
//   game_over  high in GAME_OVER
//   winner     00 none, 01 player 1, 10 player 2
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 9,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned HOLD_W      = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               p1_point,
    input  logic               p2_point,
    input  logic               serve_ack,
    output logic [SCORE_W-1:0] p1s,
    output logic [SCORE_W-1:0] p2s,
    output logic               serve_req,
    output logic               serve_dir,
    output logic               freeze,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_END = HOLD_W'(HOLD_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_d;
    logic [SCORE_W-1:0] p1s_d;
    logic [SCORE_W-1:0] p2s_d;
    logic               serve_req_d;
    logic               serve_dir_d;
    logic               freeze_d;
    logic               game_over_d;
    logic [1:0]         winner_d;

    logic               p1_rise_c;
    logic               p2_rise_c;
    logic [SCORE_W-1:0] p1_inc_c;
    logic [SCORE_W-1:0] p2_inc_c;

    point_edge_det u_p1_edge (
        .clk    (clk),
        .reset  (reset),
        .d      (p1_point),
        .rise_c (p1_rise_c)
    );

    point_edge_det u_p2_edge (
        .clk    (clk),
        .reset  (reset),
        .d      (p2_point),
        .rise_c (p2_rise_c)
    );

    assign p1_inc_c = SCORE_W'(p1s + SCORE_W'(1));
    assign p2_inc_c = SCORE_W'(p2s + SCORE_W'(1));

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        p1s_d       = p1s;
        p2s_d       = p2s;
        serve_req_d = serve_req;
        serve_dir_d = serve_dir;
        freeze_d    = freeze;
        game_over_d = game_over;
        winner_d    = winner;

        case (state_q)
            ST_IDLE: begin
                freeze_d = 1'b1;
                if (start) begin
                    state_d     = ST_SERVE;
                    p1s_d       = '0;
                    p2s_d       = '0;
                    serve_dir_d = 1'b0;
                    serve_req_d = 1'b1;
                    freeze_d    = 1'b0;
                end
            end

            ST_SERVE: begin
                if (serve_ack) begin
                    state_d     = ST_PLAY;
                    serve_req_d = 1'b0;
                end
            end

            ST_PLAY: begin
                if (p1_rise_c && p2_rise_c) begin
                    // A let: replay the point without touching score or serve side.
                    state_d  = ST_HOLD;
                    hold_d   = '0;
                    freeze_d = 1'b1;
                end else if (p1_rise_c) begin
                    p1s_d    = p1_inc_c;
                    freeze_d = 1'b1;
`ifdef SCORE_SERVE_ALT_EN
                    serve_dir_d = serve_side(p1_inc_c, p2s);
`else
                    serve_dir_d = 1'b0;
`endif
                    if (p1_inc_c == WIN_VAL) begin
                        state_d     = ST_GAME_OVER;
                        game_over_d = 1'b1;
                        winner_d    = WIN_P1;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end
                end else if (p2_rise_c) begin
                    p2s_d    = p2_inc_c;
                    freeze_d = 1'b1;
`ifdef SCORE_SERVE_ALT_EN
                    serve_dir_d = serve_side(p1s, p2_inc_c);
`else
                    serve_dir_d = 1'b1;
`endif
                    if (p2_inc_c == WIN_VAL) begin
                        state_d     = ST_GAME_OVER;
                        game_over_d = 1'b1;
                        winner_d    = WIN_P2;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end
                end
            end

            ST_HOLD: begin
                freeze_d = 1'b1;
                if (hold_q == HOLD_END) begin
                    state_d     = ST_SERVE;
                    hold_d      = '0;
                    serve_req_d = 1'b1;
                    freeze_d    = 1'b0;
                end else begin
                    hold_d = HOLD_W'(hold_q + HOLD_W'(1));
                end
            end

            ST_GAME_OVER: begin
                freeze_d = 1'b1;
                // Restart passes through IDLE so the board shows a cleared score.
                if (start) begin
                    state_d     = ST_IDLE;
                    p1s_d       = '0;
                    p2s_d       = '0;
                    serve_dir_d = 1'b0;
                    game_over_d = 1'b0;
                    winner_d    = WIN_NONE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                hold_d      = '0;
                serve_req_d = 1'b0;
                freeze_d    = 1'b1;
            end
        endcase
    end

    // State, pause counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            p1s       <= '0;
            p2s       <= '0;
            serve_req <= 1'b0;
            serve_dir <= 1'b0;
            freeze    <= 1'b1;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            p1s       <= p1s_d;
            p2s       <= p2s_d;
            serve_req <= serve_req_d;
            serve_dir <= serve_dir_d;
            freeze    <= freeze_d;
            game_over <= game_over_d;
            winner    <= winner_d;
        end
    end

endmodule
